// File: rtl/fifo_lifo_buffer_if.sv
// Handshake bundle between a producer/consumer pair and fifo_lifo_buffer.
// Latency: none; it only carries wires.
// Backpressure: full/almost_full and empty/almost_empty travel back to the master.
//
// Signals:
//   mode_sel, flush, w_en, r_en, data_in       master -> buffer
//   data_out, rd_valid, full, empty,
//   almost_full, almost_empty, count, mode,
//   overflow, underflow                        buffer -> master
interface fifo_lifo_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Requests from the producer/consumer side
    logic              mode_sel;
    logic              flush;
    logic              w_en;
    logic              r_en;
    logic [DATA_W-1:0] data_in;

    // Responses and status from the buffer
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              mode;
    logic              overflow;
    logic              underflow;

    modport master (
        output mode_sel, flush, w_en, r_en, data_in,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, mode, overflow, underflow
    );

    modport slave (
        input  mode_sel, flush, w_en, r_en, data_in,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, mode, overflow, underflow
    );
endinterface

// File: rtl/fifo_lifo_buffer.sv
// Parametrised on-chip buffer, runtime-selectable FIFO or LIFO ordering.
// Latency: accepted read returns data_out/rd_valid one cycle later; writes are visible next cycle.
// Backpressure: writes rejected when full (unless a read is accepted the same cycle), reads rejected when empty; rejects pulse overflow/underflow.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   bus (slave)    mode_sel/flush/w_en/r_en/data_in in;
//                  data_out/rd_valid/full/empty/almost_full/almost_empty/
//                  count/mode/overflow/underflow out
module fifo_lifo_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_lifo_buffer_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_AE   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = '0;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } mode_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];   // storage, deliberately not reset
    logic [ADDR_W-1:0] r_wr_ptr;        // FIFO write pointer / LIFO stack pointer
    logic [ADDR_W-1:0] r_rd_ptr;        // FIFO read pointer, idle in LIFO mode
    logic [CNT_W-1:0]  r_count;         // true occupancy 0..DEPTH
    mode_e             r_mode;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;

    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    mode_e             w_mode_nxt;
    logic              w_rd_valid_nxt;
    logic              w_overflow_nxt;
    logic              w_underflow_nxt;
    logic              w_dout_load;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [ADDR_W-1:0] w_mem_raddr;

    // Occupancy is tracked explicitly, so full/empty never depend on
    // comparing pointers that may have wrapped.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // Flush outranks every request; a read is only taken when something is
    // stored, and a full buffer still takes a write if a read frees a slot
    // in the same cycle.
    assign w_rd_acc = !bus.flush && bus.r_en && !w_empty;
    assign w_wr_acc = !bus.flush && bus.w_en && (!w_full || w_rd_acc);

    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_count_nxt     = r_count;
        w_mode_nxt      = r_mode;
        w_rd_valid_nxt  = 1'b0;
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
        w_dout_load     = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_waddr     = r_wr_ptr;
        // LIFO reads the top of stack, one below the stack pointer; at a
        // full stack the pointer has wrapped to 0 and this lands on DEPTH-1.
        w_mem_raddr     = (r_mode == MODE_LIFO) ? (r_wr_ptr - PTR_ONE) : r_rd_ptr;

        if (bus.flush) begin
            w_wr_ptr_nxt = PTR_ZERO;
            w_rd_ptr_nxt = PTR_ZERO;
            w_count_nxt  = '0;
        end else begin
            w_overflow_nxt  = bus.w_en && w_full && !w_rd_acc;
            w_underflow_nxt = bus.r_en && w_empty;

            // Mode may only switch while nothing is stored and nothing is
            // being written, so the two orderings never see each other's
            // pointer layout. An empty buffer also means no read is taken.
            if (w_empty && !w_wr_acc && (mode_e'(bus.mode_sel) != r_mode)) begin
                w_mode_nxt   = mode_e'(bus.mode_sel);
                w_wr_ptr_nxt = PTR_ZERO;
                w_rd_ptr_nxt = PTR_ZERO;
            end

            if (w_rd_acc) begin
                w_dout_load    = 1'b1;
                w_rd_valid_nxt = 1'b1;
            end

            if (w_wr_acc) begin
                w_mem_we = 1'b1;
            end

            if (r_mode == MODE_FIFO) begin
                if (w_wr_acc) begin
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                end
                if (w_rd_acc) begin
                    w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
                end
            end else begin
                if (w_wr_acc && w_rd_acc) begin
                    // Push and pop together: the old top goes out and the
                    // new word overwrites it in place; the stack pointer holds.
                    w_mem_waddr = r_wr_ptr - PTR_ONE;
                end else if (w_wr_acc) begin
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                end else if (w_rd_acc) begin
                    w_wr_ptr_nxt = r_wr_ptr - PTR_ONE;
                end
            end

            if (w_wr_acc && !w_rd_acc) begin
                w_count_nxt = r_count + CNT_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                w_count_nxt = r_count - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_count     <= '0;
            r_mode      <= MODE_FIFO;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_mode      <= w_mode_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
            // data_out holds its last value between reads and across flush.
            if (w_dout_load) begin
                r_data_out <= r_mem[w_mem_raddr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: plain synchronous-write array, no reset so it can map to RAM.
    // A replace-top reads the old word and writes the new one on the same
    // edge; the read above sees the pre-edge contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: status is combinational from the registered occupancy.
    // ------------------------------------------------------------------
    assign bus.data_out     = r_data_out;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CNT_AF);
    assign bus.almost_empty = (r_count <= CNT_AE);
    assign bus.count        = r_count;
    assign bus.mode         = r_mode;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_lifo_buffer.sv
// Self-checking bench for fifo_lifo_buffer (DEPTH=8, DATA_W=16).
// Directed vector table, an async-reset sequence, then random traffic against a queue model.
// Inputs are driven after the rising edge; outputs are sampled 1 time unit after it.
module tb_fifo_lifo_buffer;

    localparam int DW = 16;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_lifo_buffer_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    fifo_lifo_buffer #(
        .DATA_W  (DW),
        .DEPTH   (DP),
        .AF_LEVEL(DP - 2),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic          ms;
        logic          fl;
        logic          we;
        logic          re;
        logic [DW-1:0] din;
        int            cnt;
        logic [DW-1:0] dout;
        logic          rv;
        logic          of;
        logic          uf;
        logic          md;
    } vec_t;

    vec_t vt[$];

    // Reference model state
    logic [DW-1:0] mq[$];
    logic          m_mode;
    logic [DW-1:0] m_dout;
    logic          m_rv;
    logic          m_of;
    logic          m_uf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input logic [DW-1:0] dout,
                             input logic rv, input logic of, input logic uf, input logic md);
        chk({tag, " count"},        32'(bus.count),        32'(cnt));
        chk({tag, " full"},         32'(bus.full),         32'(cnt == DP));
        chk({tag, " empty"},        32'(bus.empty),        32'(cnt == 0));
        chk({tag, " almost_full"},  32'(bus.almost_full),  32'(cnt >= DP - 2));
        chk({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= 2));
        chk({tag, " data_out"},     32'(bus.data_out),     32'(dout));
        chk({tag, " rd_valid"},     32'(bus.rd_valid),     32'(rv));
        chk({tag, " overflow"},     32'(bus.overflow),     32'(of));
        chk({tag, " underflow"},    32'(bus.underflow),    32'(uf));
        chk({tag, " mode"},         32'(bus.mode),         32'(md));
    endtask

    task automatic drive(input logic ms, input logic fl, input logic we, input logic re,
                         input logic [DW-1:0] din);
        bus.mode_sel = ms;
        bus.flush    = fl;
        bus.w_en     = we;
        bus.r_en     = re;
        bus.data_in  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ms, input logic fl, input logic we, input logic re,
                       input logic [DW-1:0] din, input int cnt, input logic [DW-1:0] dout,
                       input logic rv, input logic of, input logic uf, input logic md);
        vec_t v;
        v.ms = ms; v.fl = fl; v.we = we; v.re = re; v.din = din;
        v.cnt = cnt; v.dout = dout; v.rv = rv; v.of = of; v.uf = uf; v.md = md;
        vt.push_back(v);
    endtask

    // Behavioural model: a queue is the buffer; FIFO pops the front, LIFO the back.
    task automatic model_step(input logic ms, input logic fl, input logic we, input logic re,
                              input logic [DW-1:0] din);
        int  sz;
        bit  rd_ok;
        bit  wr_ok;
        sz   = mq.size();
        m_rv = 1'b0;
        m_of = 1'b0;
        m_uf = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            rd_ok = re && (sz > 0);
            wr_ok = we && ((sz < DP) || rd_ok);
            m_uf  = re && (sz == 0);
            m_of  = we && (sz == DP) && !rd_ok;
            if ((sz == 0) && !wr_ok) m_mode = ms;
            if (rd_ok) begin
                m_dout = m_mode ? mq.pop_back() : mq.pop_front();
                m_rv   = 1'b1;
            end
            if (wr_ok) mq.push_back(din);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ms_r;
        int   wbias;
        logic fl_r, we_r, re_r;
        logic [DW-1:0] din_r;

        // ---------------- Vector table ----------------
        // FIFO fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, DW'(i), i, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 16'h0009, 8, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 0, 0, 1, 0, 8 - i, DW'(i), 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 16'h0008, 0, 0, 1, 0);
        // write+read while empty: write only, no bypass
        add(0, 0, 1, 1, 16'h005A, 1, 16'h0008, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'h005A, 1, 0, 0, 0);
        // wrap-around
        for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 16'h0010 + DW'(i), i + 1, 16'h005A, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 0, 5 - i, 16'h0010 + DW'(i), 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 16'h00A0 + DW'(i), i + 1, 16'h0015, 0, 0, 0, 0);
        // simultaneous read+write at full
        add(0, 0, 1, 1, 16'h0055, 8, 16'h00A0, 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 1, 0, 8 - i, 16'h00A0 + DW'(i), 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 16'h0055, 1, 0, 0, 0);
        // LIFO
        add(1, 0, 0, 0, 0, 0, 16'h0055, 0, 0, 0, 1);
        add(1, 0, 1, 0, 16'h0011, 1, 16'h0055, 0, 0, 0, 1);
        add(1, 0, 1, 0, 16'h0022, 2, 16'h0055, 0, 0, 0, 1);
        add(1, 0, 1, 0, 16'h0033, 3, 16'h0055, 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, 2, 16'h0033, 1, 0, 0, 1);
        add(1, 0, 1, 1, 16'h0044, 2, 16'h0022, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 1, 16'h0044, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 16'h0011, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 16'h0011, 0, 0, 1, 1);
        add(1, 0, 1, 1, 16'h0066, 1, 16'h0011, 0, 0, 1, 1);
        add(1, 0, 0, 1, 0, 0, 16'h0066, 1, 0, 0, 1);
        // LIFO full, overflow, replace at full, flush ignoring requests
        for (int i = 1; i <= 8; i++) add(1, 0, 1, 0, 16'h0080 + DW'(i), i, 16'h0066, 0, 0, 0, 1);
        add(1, 0, 1, 0, 16'h0099, 8, 16'h0066, 0, 1, 0, 1);
        add(1, 0, 1, 1, 16'h00AA, 8, 16'h0088, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 7, 16'h00AA, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 6, 16'h0087, 1, 0, 0, 1);
        add(1, 1, 1, 1, 16'h0077, 0, 16'h0087, 0, 0, 0, 1);
        // back to FIFO, then mode change ignored while non-empty
        add(0, 0, 0, 0, 0, 0, 16'h0087, 0, 0, 0, 0);
        add(0, 0, 1, 0, 16'h0071, 1, 16'h0087, 0, 0, 0, 0);
        add(0, 0, 1, 0, 16'h0072, 2, 16'h0087, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2, 16'h0087, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 16'h0087, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h0087, 0, 0, 0, 1);
        // write at empty blocks the mode update
        add(0, 0, 1, 0, 16'h0031, 1, 16'h0087, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 16'h0031, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 16'h0031, 0, 0, 0, 0);

        // ---------------- Reset ----------------
        bus.mode_sel = 0; bus.flush = 0; bus.w_en = 0; bus.r_en = 0; bus.data_in = '0;
        #2;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        for (int k = 0; k < vt.size(); k++) begin
            drive(vt[k].ms, vt[k].fl, vt[k].we, vt[k].re, vt[k].din);
            check_all($sformatf("vec%0d", k), vt[k].cnt, vt[k].dout, vt[k].rv,
                      vt[k].of, vt[k].uf, vt[k].md);
        end

        // ---------------- Async reset mid-burst ----------------
        drive(0, 0, 1, 0, 16'h00B1);
        drive(0, 0, 1, 0, 16'h00B2);
        drive(0, 0, 0, 1, 0);
        check_all("pre_arst", 1, 16'h00B1, 1, 0, 0, 0);
        bus.w_en = 1; bus.r_en = 0; bus.data_in = 16'h00B3;
        #2;
        rst = 1'b0;
        #1;
        check_all("arst_now", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_all("arst_hold", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 1, 0);
        check_all("post_arst", 0, 0, 0, 0, 1, 0);

        // ---------------- Random vs model ----------------
        mq.delete();
        m_mode = 0; m_dout = '0; m_rv = 0; m_of = 0; m_uf = 0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        ms_r = 1'b0;
        for (int k = 0; k < 800; k++) begin
            wbias = ((k / 48) % 2 == 0) ? 3 : 1;
            if ($urandom_range(0, 19) == 0) ms_r = ~ms_r;
            fl_r  = ($urandom_range(0, 40) == 0);
            we_r  = ($urandom_range(0, 3) < wbias);
            re_r  = ($urandom_range(0, 3) < (4 - wbias));
            din_r = DW'($urandom);
            model_step(ms_r, fl_r, we_r, re_r, din_r);
            drive(ms_r, fl_r, we_r, re_r, din_r);
            check_all($sformatf("rnd%0d", k), mq.size(), m_dout, m_rv, m_of, m_uf, m_mode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_lifo_buffer.md
Name: fifo_lifo_buffer

Overview:
Parametrised successor to the team's fixed 32x32 FIFO: configurable width and depth, with a runtime-selectable FIFO or LIFO mode. Full/empty use a true occupancy count and stay correct across pointer wrap-around. Adds almost-full/almost-empty flags, occupancy output, flush, read-valid strobe, and overflow/underflow error pulses. Used as the common on-chip buffer between producer and consumer stages in the lab datapaths.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=2; ADDR_W = log2(DEPTH)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (assert 0 = reset)
mode_sel  in  1  requested mode: 0 FIFO, 1 LIFO
flush  in  1  synchronous clear of contents
w_en  in  1  write/push request
r_en  in  1  read/pop request
data_in  in  DATA_W  write data
data_out  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse: data_out updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
mode  out  1  active mode
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, count=0, mode=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset. Flags follow from count: empty=1, full=0.
- Flags and count are combinational from the registered count. count changes one cycle after an accepted operation.
- Priority, highest first: rst, flush, mode update, read/write.
- flush=1: pointers and count go to 0. data_out holds. rd_valid, overflow and underflow are 0. w_en and r_en are ignored that cycle.
- Mode update: mode <= mode_sel only when count==0, flush=0 and no write is accepted that cycle. Otherwise mode_sel is ignored. On an update, both pointers are cleared.
- Accept rules: read accepted iff r_en && !empty. Write accepted iff w_en && (!full || read accepted).
  - r_en while empty gives an underflow pulse.
  - w_en while full with no accepted read gives an overflow pulse. State does not change on a rejected operation.
- Read latency: 1 cycle. Accepted read at edge N gives data_out and rd_valid=1 after edge N. data_out holds between reads. rd_valid is 0 otherwise.
- FIFO mode:
  - Write: mem[wr_ptr]<=data_in, wr_ptr++.
  - Read: data_out<=mem[rd_ptr], rd_ptr++.
  - Pointers wrap modulo DEPTH.
  - Simultaneous accepted read and write: both proceed, count unchanged; valid when full.
  - Write while empty: no same-cycle bypass; data is readable from the next cycle.
- LIFO mode (wr_ptr is stack pointer, rd_ptr unused):
  - Push: mem[wr_ptr]<=data_in, wr_ptr++.
  - Pop: data_out<=mem[wr_ptr-1], wr_ptr--.
  - Simultaneous push and pop with count>0: data_out<=mem[wr_ptr-1], mem[wr_ptr-1]<=data_in, wr_ptr and count unchanged (replace top).
  - Push with pop while empty: push only, plus an underflow pulse.
- count arithmetic: +1 on write only, -1 on read only, unchanged otherwise. It never leaves 0..DEPTH.
- Reset mid-operation: takes effect immediately regardless of clk. Any in-flight read is lost and rd_valid=0.

Test Plan:
- Reset and fill (DEPTH=8, DATA_W=16, FIFO): hold rst=0, then write 0x0001..0x0008 → full=1, count=8, almost_full=1 from count 6. 9th write → overflow pulse, count stays 8. Read 8 words → 0x0001..0x0008 in order, each with rd_valid one cycle after r_en. Then empty=1.
- Wrap-around (FIFO): write 6, read 6, write 8 (0xA0..0xA7) → full at count 8 (pointers wrapped). Reads return 0xA0..0xA7. No false empty or full.
- Simultaneous read and write at full (FIFO): 8 entries, w_en=r_en=1 with data_in=0x55 → count stays 8, oldest word out, 0x55 appears last.
- LIFO: set mode_sel=1 while empty, push 0x11,0x22,0x33, pop → 0x33. Push+pop with 0x44 → data_out=0x22, top replaced by 0x44. Pop, pop → 0x44, then 0x11, empty=1. Further pop → underflow pulse.
- Mode change ignored when non-empty: write 2 words in FIFO, set mode_sel=1 → mode stays 0. Flush → count=0, data_out unchanged. The next cycle with mode_sel=1 gives mode=1.
- Async reset mid-burst: during alternating writes and reads, drop rst between edges → count=0, empty=1, data_out=0, rd_valid=0 immediately, before the next clk edge.
